row_p2s: RTL and testbench

Per-row parallel-to-serial output stage between the end of a row's FSM_BLOCK daisy chain and the chip's serial data pins. Each bench row ends in one `row_p2s`, and the downstream S2P deserializer consumes its `s_data`/`data_valid` pair. The block does four things:
- captures the 13-bit words leaving the last block and discards idle words;
- buffers the payloads in a FIFO;
- waits until a complete frame is buffered;
- shifts the frame out MSB first with `data_valid` framing.

---
 rtl/row_p2s.sv | 173 +++++++++++++++++
 tb/tb_row_p2s.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/row_p2s.sv
// row_p2s: per-row parallel-to-serial output stage.
// Filters idle words, buffers payloads, shifts whole frames out MSB first.
// Ports: clk_50M, rst_n (async, active low); p_data/p_strobe daisy-chain
// input; clr_ovf clears the sticky overflow; s_data/data_valid serial out;
// overflow flags a dropped payload; fifo_level is current occupancy.
// Optional: define ROW_P2S_PARITY_EN to append an even-parity bit per word.
module row_p2s #(
  parameter int BITS_ADC        = 12,
  parameter int WORDS_PER_FRAME = 32,
  parameter int FIFO_DEPTH      = 64,
  parameter int GAP_CYCLES      = 2
) (
  input  logic                          clk_50M,
  input  logic                          rst_n,
  input  logic [BITS_ADC:0]             p_data,
  input  logic                          p_strobe,
  input  logic                          clr_ovf,
  output logic                          s_data,
  output logic                          data_valid,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
`ifdef ROW_P2S_PARITY_EN
  localparam int SW = BITS_ADC + 1;
`else
  localparam int SW = BITS_ADC;
`endif
  localparam int BW = (SW > 1) ? $clog2(SW) : 1;
  localparam int WW = (WORDS_PER_FRAME > 1) ?
                      $clog2(WORDS_PER_FRAME) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [SW-1:0]       sr_q, sr_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [WW-1:0]       word_q, word_d;
  logic [GW-1:0]       gap_q, gap_d;
  logic                sd_q, sd_d;
  logic                dv_q, dv_d;
  logic                ovf_q, ovf_d;
  logic [LW-1:0]       lvl_q, lvl_d;
  logic [AW-1:0]       wptr_q, rptr_q;
  logic [BITS_ADC-1:0] mem_q [FIFO_DEPTH];

  logic                rd;
  logic                wr_req;
  logic                wr_en;
  logic                full;
  logic                drop;
  logic [BITS_ADC-1:0] head;
  logic [SW-1:0]       load_w;

  assign head   = mem_q[rptr_q];
`ifdef ROW_P2S_PARITY_EN
  assign load_w = {head, ^head};
`else
  assign load_w = head;
`endif

  // A same-cycle pop frees the slot, so a full FIFO still
  // accepts the write when a read happens on that edge.
  assign wr_req = p_strobe & ~p_data[BITS_ADC];
  assign full   = (lvl_q == LW'(FIFO_DEPTH));
  assign wr_en  = wr_req & (~full | rd);
  assign drop   = wr_req & full & ~rd;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bit_d   = bit_q;
    word_d  = word_q;
    gap_d   = gap_q;
    sd_d    = 1'b0;
    dv_d    = 1'b0;
    rd      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (lvl_q >= LW'(WORDS_PER_FRAME)) begin
          rd      = 1'b1;
          sr_d    = load_w;
          bit_d   = '0;
          word_d  = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sd_d = sr_q[SW-1];
        dv_d = 1'b1;
        if (bit_q == BW'(SW - 1)) begin
          if (word_q == WW'(WORDS_PER_FRAME - 1)) begin
            gap_d   = '0;
            state_d = GAP;
          end else begin
            rd     = 1'b1;
            sr_d   = load_w;
            bit_d  = '0;
            word_d = word_q + WW'(1);
          end
        end else begin
          sr_d  = sr_q << 1;
          bit_d = bit_q + BW'(1);
        end
      end
      GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lvl_d = lvl_q;
    case ({wr_en, rd})
      2'b10:   lvl_d = lvl_q + LW'(1);
      2'b01:   lvl_d = lvl_q - LW'(1);
      default: lvl_d = lvl_q;
    endcase
  end

  // A new drop beats a same-cycle clear.
  assign ovf_d = drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);

  always_ff @(posedge clk_50M) begin
    if (wr_en) mem_q[wptr_q] <= p_data[BITS_ADC-1:0];
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      bit_q   <= '0;
      word_q  <= '0;
      gap_q   <= '0;
      sd_q    <= 1'b0;
      dv_q    <= 1'b0;
      ovf_q   <= 1'b0;
      lvl_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bit_q   <= bit_d;
      word_q  <= word_d;
      gap_q   <= gap_d;
      sd_q    <= sd_d;
      dv_q    <= dv_d;
      ovf_q   <= ovf_d;
      lvl_q   <= lvl_d;
      if (wr_en) wptr_q <= wptr_q + AW'(1);
      if (rd)    rptr_q <= rptr_q + AW'(1);
    end
  end

  assign s_data     = sd_q;
  assign data_valid = dv_q;
  assign overflow   = ovf_q;
  assign fifo_level = lvl_q;

endmodule

// File: tb/tb_row_p2s.sv
// tb_row_p2s: self-checking bench for row_p2s.
// Frame-schedule model plus directed, hand-computed checks.
module tb_row_p2s;

  localparam int BITS  = 12;
  localparam int WPF   = 32;
  localparam int DEPTH = 64;
  localparam int GAP   = 2;
`ifdef ROW_P2S_PARITY_EN
  localparam int SW = BITS + 1;
`else
  localparam int SW = BITS;
`endif
  localparam int FB = SW * WPF;

  logic        clk_50M = 1'b0;
  logic        rst_n   = 1'b0;
  logic [12:0] p_data  = '0;
  logic        p_strobe = 1'b0;
  logic        clr_ovf  = 1'b0;
  logic        s_data;
  logic        data_valid;
  logic        overflow;
  logic [6:0]  fifo_level;

  row_p2s dut (
    .clk_50M    (clk_50M),
    .rst_n      (rst_n),
    .p_data     (p_data),
    .p_strobe   (p_strobe),
    .clr_ovf    (clr_ovf),
    .s_data     (s_data),
    .data_valid (data_valid),
    .overflow   (overflow),
    .fifo_level (fifo_level)
  );

  always #10 clk_50M = ~clk_50M;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int frames = 0;
  bit dv_prev = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Model: a frame starting at edge S pops word k at S+k*SW,
  // shows bit j after edge S+1+j, and the next frame may
  // start no earlier than S+FB+GAP+1.
  logic [11:0] m_q [$];
  logic [11:0] fw [WPF];
  int  start_e = -100000;
  int  next_ok = 0;
  bit  m_ovf = 0;
  bit  e_dv = 0;
  bit  e_sd = 0;

  always @(posedge clk_50M) begin
    int d, j, w, b;
    bit drop;
    cyc++;
    if (!rst_n) begin
      m_q.delete();
      start_e = -100000;
      next_ok = 0;
      m_ovf = 0;
      e_dv = 0;
      e_sd = 0;
    end else begin
      d = cyc - start_e;
      if (d > 0 && d < FB && d % SW == 0) begin
        fw[d / SW] = m_q.pop_front();
      end else if (cyc >= next_ok && m_q.size() >= WPF) begin
        start_e = cyc;
        next_ok = cyc + FB + GAP + 1;
        fw[0] = m_q.pop_front();
      end
      drop = 0;
      if (p_strobe && !p_data[BITS]) begin
        if (m_q.size() < DEPTH) m_q.push_back(p_data[BITS-1:0]);
        else drop = 1;
      end
      if (drop) m_ovf = 1;
      else if (clr_ovf) m_ovf = 0;
      d = cyc - start_e;
      if (d >= 1 && d <= FB) begin
        j = d - 1;
        w = j / SW;
        b = j % SW;
        e_dv = 1;
        e_sd = (b < BITS) ? fw[w][BITS-1-b] : ^fw[w];
      end else begin
        e_dv = 0;
        e_sd = 0;
      end
    end
  end

  always @(negedge clk_50M) begin
    if (data_valid && !dv_prev) frames++;
    dv_prev = data_valid;
    if (rst_n) begin
      chk("m_level", int'(fifo_level), m_q.size());
      chk("m_ovf", int'(overflow), int'(m_ovf));
      chk("m_dv", int'(data_valid), int'(e_dv));
      chk("m_sdata", int'(s_data), int'(e_sd));
    end
  end

  logic bits [0:1023];

  task automatic tick();
    @(posedge clk_50M);
    #1;
  endtask

  task automatic wr(input logic [12:0] d);
    p_data = d;
    p_strobe = 1'b1;
    tick();
    p_strobe = 1'b0;
    p_data = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_rise(input string nm);
    int n = 0;
    while (!data_valid && n < 200) begin
      tick();
      n++;
    end
    chk(nm, int'(data_valid), 1);
  endtask

  task automatic capture(output int len);
    len = 0;
    while (data_valid && len < 1000) begin
      bits[len] = s_data;
      len++;
      tick();
    end
  endtask

  initial begin
    int len, g, f0;
    logic [11:0] w;
    int v;

    // 1: reset and single frame
    tick();
    tick();
    chk("rst_dv", int'(data_valid), 0);
    chk("rst_sd", int'(s_data), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_lvl", int'(fifo_level), 0);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 32; i++) begin
      wr(13'(i));
      if (i < 31) repeat (3) tick();
    end
    chk("t1_lvl32", int'(fifo_level), 32);
    tick();
    chk("t1_dv_n1", int'(data_valid), 0);
    tick();
    chk("t1_dv_n2", int'(data_valid), 1);
    capture(len);
    chk("t1_len", len, FB);
    for (int k = 0; k < 32; k++) begin
      w = '0;
      for (int b = 0; b < BITS; b++) w = {w[10:0], bits[k*SW+b]};
      chk("t1_word", int'(w), k);
    end
    chk("t1_lvl_end", int'(fifo_level), 0);

    // 2: idle filtering
    do_reset();
    f0 = frames;
    v = 0;
    for (int i = 0; i < 52; i++) begin
      if (i < 40 && (i % 2) == 1) wr(13'h1FFF);
      else begin
        wr(13'(12'h100 + v));
        v++;
      end
    end
    chk("t2_peak", int'(fifo_level), 32);
    wait_rise("t2_rise");
    capture(len);
    chk("t2_len", len, FB);
    repeat (100) tick();
    chk("t2_frames", frames - f0, 1);

    // 3: overflow
    do_reset();
    for (int i = 0; i < 31; i++) wr(13'(12'h200 + i));
    repeat (20) tick();
    chk("t3_stall_dv", int'(data_valid), 0);
    chk("t3_stall_lvl", int'(fifo_level), 31);
    for (int k = 1; k <= 40; k++) begin
      if (k == 40) clr_ovf = 1'b1;
      wr(13'(12'h300 + k));
      clr_ovf = 1'b0;
      if (k == 36) begin
        chk("t3_ovf36", int'(overflow), 0);
        chk("t3_lvl36", int'(fifo_level), 64);
      end
      if (k == 37) chk("t3_ovf37", int'(overflow), 1);
      if (k == 40) chk("t3_setwins", int'(overflow), 1);
    end
    chk("t3_lvl_max", int'(fifo_level), 64);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("t3_clr", int'(overflow), 0);
    repeat (50) tick();

    // 4: back-to-back frames
    do_reset();
    for (int k = 1; k <= 64; k++) begin
      wr(13'(12'h400 + k));
      if (k == 32) chk("t4_lvl32", int'(fifo_level), 32);
      if (k == 33) chk("t4_wr_rd", int'(fifo_level), 32);
    end
    chk("t4_lvl64", int'(fifo_level), 61);
    g = 0;
    while (data_valid && g < 1000) begin
      tick();
      g++;
    end
    g = 0;
    while (!data_valid && g < 50) begin
      tick();
      g++;
    end
    chk("t4_gap", g, GAP + 1);
    capture(len);
    chk("t4_len2", len, FB);
    chk("t4_lvl_end", int'(fifo_level), 0);

    // 5: reset mid-frame
    do_reset();
    for (int i = 0; i < 32; i++) wr(13'(12'h500 + i));
    wait_rise("t5_rise");
    repeat (100) tick();
    rst_n = 1'b0;
    #1;
    chk("t5_dv", int'(data_valid), 0);
    chk("t5_sd", int'(s_data), 0);
    chk("t5_lvl", int'(fifo_level), 0);
    tick();
    tick();
    rst_n = 1'b1;
    f0 = frames;
    repeat (600) tick();
    chk("t5_quiet", frames - f0, 0);
    chk("t5_lvl0", int'(fifo_level), 0);
    for (int i = 0; i < 31; i++) wr(13'(12'h600 + i));
    repeat (50) tick();
    chk("t5_31w", frames - f0, 0);
    wr(13'h0777);
    repeat (3) tick();
    chk("t5_32w", frames - f0, 1);
    repeat (FB + 10) tick();

`ifdef ROW_P2S_PARITY_EN
    // 6: parity
    do_reset();
    wr(13'h0007);
    wr(13'h0003);
    for (int i = 0; i < 30; i++) wr(13'h00A5);
    wait_rise("t6_rise");
    capture(len);
    chk("t6_len", len, 416);
    chk("t6_par7", int'(bits[12]), 1);
    chk("t6_par3", int'(bits[25]), 0);
    w = '0;
    for (int b = 0; b < BITS; b++) w = {w[10:0], bits[13+b]};
    chk("t6_word1", int'(w), 3);
`endif

    repeat (10) tick();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
